// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results to WB and runs a req/resp handshake for loads/stores.
// Optional misaligned-access trap is compiled in when MEM_MISALIGN_CHECK_EN is defined.
module mem_stage #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validM,
    input  logic [DATA_W-1:0] aluResM,
    input  logic [DATA_W-1:0] storeDataM,
    input  logic [4:0]        memOpM,
    input  logic              rdWriteEnableM,
    input  logic [RD_W-1:0]   rdWriteAddrM,
    output logic              stallM,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [7:0]        memWstrb,
    input  logic              memReady,
    input  logic              memRvalid,
    input  logic [DATA_W-1:0] memRdata,
    output logic              rdWriteEnableW,
    output logic [RD_W-1:0]   rdWriteAddrW,
    output logic [DATA_W-1:0] rdWriteDataW,
    output logic              misalignW
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic              capture;
    logic              misalign;
    logic              mem_go;
    logic [2:0]        off;
    logic [1:0]        size;
    logic              is_store;
    logic              is_unsigned;
    logic              rd_nonzero;
    logic [7:0]        size_mask;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;

    assign off         = aluResM[2:0];
    assign size        = memOpM[1:0];
    assign is_store    = memOpM[3];
    assign is_unsigned = memOpM[2];
    assign rd_nonzero  = |rdWriteAddrM;

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        case (size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = aluResM[0];
            2'd2:    misalign = |aluResM[1:0];
            default: misalign = |aluResM[2:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign mem_go = validM & memOpM[4] & ~misalign;

    // Gated by rst so an in-flight access releases upstream the instant reset asserts.
    assign stallM = ~rst & (((state == IDLE) & mem_go) | (state == REQ) | (state == RESP));
    assign memReq = (state == REQ);

    always_comb begin
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign memWe    = is_store;
    assign memAddr  = {aluResM[DATA_W-1:3], 3'b000};
    assign memWstrb = size_mask << off;
    assign memWdata = storeDataM << {off, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: if (mem_go) next_state = REQ;
            REQ: begin
                if (memReady) begin
                    if (memRvalid) begin
                        capture    = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            RESP: begin
                if (memRvalid) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this data register is reset so a stale value can never reach WB after reset.
        if (rst)          cap_data <= '0;
        else if (capture) cap_data <= memRdata;
    end

    assign shifted = cap_data >> {off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            2'd0: load_data = is_unsigned ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                                          : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            2'd1: load_data = is_unsigned ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                                          : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            2'd2: load_data = is_unsigned ? {{(DATA_W-32){1'b0}}, shifted[31:0]}
                                          : {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdWriteEnableW <= 1'b0;
            rdWriteAddrW   <= '0;
            rdWriteDataW   <= '0;
        end else if (state == DONE) begin
            rdWriteEnableW <= validM & rdWriteEnableM & ~is_store & rd_nonzero;
            rdWriteAddrW   <= rdWriteAddrM;
            rdWriteDataW   <= load_data;
        end else if (stallM) begin
            rdWriteEnableW <= 1'b0;
        end else begin
            // A misaligned mem op lands here too and must not write back.
            rdWriteEnableW <= validM & ~memOpM[4] & rdWriteEnableM & rd_nonzero;
            rdWriteAddrW   <= rdWriteAddrM;
            rdWriteDataW   <= aluResM;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= (state == IDLE) & validM & memOpM[4] & misalign;
    end

    assign misalignW = misalign_q;
`else
    assign misalignW = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven ALU and memory vectors plus reset/misalign sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        validM;
    logic [63:0] aluResM;
    logic [63:0] storeDataM;
    logic [4:0]  memOpM;
    logic        rdWriteEnableM;
    logic [4:0]  rdWriteAddrM;
    logic        stallM;
    logic        memReq;
    logic        memWe;
    logic [63:0] memAddr;
    logic [63:0] memWdata;
    logic [7:0]  memWstrb;
    logic        memReady;
    logic        memRvalid;
    logic [63:0] memRdata;
    logic        rdWriteEnableW;
    logic [4:0]  rdWriteAddrW;
    logic [63:0] rdWriteDataW;
    logic        misalignW;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.DATA_W(64), .RD_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .validM         (validM),
        .aluResM        (aluResM),
        .storeDataM     (storeDataM),
        .memOpM         (memOpM),
        .rdWriteEnableM (rdWriteEnableM),
        .rdWriteAddrM   (rdWriteAddrM),
        .stallM         (stallM),
        .memReq         (memReq),
        .memWe          (memWe),
        .memAddr        (memAddr),
        .memWdata       (memWdata),
        .memWstrb       (memWstrb),
        .memReady       (memReady),
        .memRvalid      (memRvalid),
        .memRdata       (memRdata),
        .rdWriteEnableW (rdWriteEnableW),
        .rdWriteAddrW   (rdWriteAddrW),
        .rdWriteDataW   (rdWriteDataW),
        .misalignW      (misalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  op;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        en;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [63:0] exp_data;
    } alu_vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        en;
        int          ready_dly;
        int          rvalid_dly;
        logic        stale;
        logic [63:0] exp_maddr;
        logic        exp_mwe;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic        exp_wbwe;
        logic        chk_data;
        logic [63:0] exp_data;
    } mem_vec_t;

    alu_vec_t av[6];
    mem_vec_t mv[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        validM         = 1'b0;
        memOpM         = 5'd0;
        aluResM        = 64'd0;
        storeDataM     = 64'd0;
        rdWriteEnableM = 1'b0;
        rdWriteAddrM   = 5'd0;
        memReady       = 1'b0;
        memRvalid      = 1'b0;
        memRdata       = 64'd0;
    endtask

    task automatic run_mem(input mem_vec_t v, input string tag);
        int stalls;
        int reqs;
        validM         = 1'b1;
        memOpM         = v.op;
        aluResM        = v.addr;
        storeDataM     = v.wdata;
        rdWriteAddrM   = v.rd;
        rdWriteEnableM = v.en;
        memReady       = 1'b0;
        memRvalid      = 1'b0;
        memRdata       = ~v.rdata;
        stalls = 0;
        reqs   = 0;
        #1;
        if (stallM) stalls++;
        if (memReq) reqs++;
        step();
        for (int c = 0; c <= v.ready_dly; c++) begin
            if (memReq) reqs++;
            if (c == v.ready_dly) begin
                check({tag, "_req"},   {63'd0, memReq}, 64'd1);
                check({tag, "_maddr"}, memAddr, v.exp_maddr);
                check({tag, "_mwe"},   {63'd0, memWe}, {63'd0, v.exp_mwe});
                check({tag, "_strb"},  {56'd0, memWstrb}, {56'd0, v.exp_strb});
                if (v.exp_mwe) check({tag, "_wdata"}, memWdata, v.exp_wdata);
            end
            memReady  = (c == v.ready_dly);
            memRvalid = memReady ? (v.rvalid_dly == 0) : v.stale;
            memRdata  = (memReady && v.rvalid_dly == 0) ? v.rdata : ~v.rdata;
            #1;
            if (stallM) stalls++;
            step();
            memReady  = 1'b0;
            memRvalid = 1'b0;
            memRdata  = ~v.rdata;
        end
        for (int k = 1; k <= v.rvalid_dly; k++) begin
            memRvalid = (k == v.rvalid_dly);
            memRdata  = memRvalid ? v.rdata : ~v.rdata;
            #1;
            if (stallM) stalls++;
            if (memReq) reqs++;
            step();
            memRvalid = 1'b0;
            memRdata  = ~v.rdata;
        end
        #1;
        check({tag, "_done_stall"}, {63'd0, stallM}, 64'd0);
        step();
        check({tag, "_wb_we"},   {63'd0, rdWriteEnableW}, {63'd0, v.exp_wbwe});
        check({tag, "_wb_addr"}, {59'd0, rdWriteAddrW}, {59'd0, v.rd});
        if (v.chk_data) check({tag, "_wb_data"}, rdWriteDataW, v.exp_data);
        check({tag, "_misalign"}, {63'd0, misalignW}, 64'd0);
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(2 + v.ready_dly + v.rvalid_dly));
        check({tag, "_req_cycles"}, 64'(reqs), 64'(1 + v.ready_dly));
        idle_inputs();
    endtask

    initial begin
        //           valid op        alu                     rd  en  we  addr data
        av[0] = '{1'b1, 5'b00000, 64'h1234,               5,  1, 1, 5,  64'h1234};
        av[1] = '{1'b1, 5'b00000, 64'hDEAD,               0,  1, 0, 0,  64'hDEAD};
        av[2] = '{1'b0, 5'b00000, 64'h55,                 7,  1, 0, 7,  64'h55};
        av[3] = '{1'b1, 5'b00000, 64'hFFFF_FFFF_FFFF_FFFF, 31, 0, 0, 31, 64'hFFFF_FFFF_FFFF_FFFF};
        av[4] = '{1'b1, 5'b00000, 64'h8000_0000_0000_0001, 31, 1, 1, 31, 64'h8000_0000_0000_0001};
        av[5] = '{1'b0, 5'b10010, 64'h77,                 8,  1, 0, 8,  64'h77};

        //         op        addr      wdata                   rdata                   rd en rdy rv stale maddr     mwe strb   wdata_exp               wbwe chk data
        mv[0] = '{5'b10000, 64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 3,  1, 0, 0, 0, 64'h1000, 0, 8'h08, 64'h0,                  1, 1, 64'hFFFF_FFFF_FFFF_FF80};
        mv[1] = '{5'b10100, 64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 3,  1, 0, 0, 0, 64'h1000, 0, 8'h08, 64'h0,                  1, 1, 64'h80};
        mv[2] = '{5'b11001, 64'h2006, 64'hABCD,               64'h0,                  9,  1, 2, 3, 1, 64'h2000, 1, 8'hC0, 64'hABCD_0000_0000_0000, 0, 0, 64'h0};
        mv[3] = '{5'b10011, 64'h3008, 64'h0,                  64'h1122_3344_5566_7788, 0,  1, 1, 1, 0, 64'h3008, 0, 8'hFF, 64'h0,                  0, 0, 64'h0};
        mv[4] = '{5'b10010, 64'h4004, 64'h0,                  64'h8765_4321_0000_0000, 10, 1, 0, 2, 0, 64'h4000, 0, 8'hF0, 64'h0,                  1, 1, 64'hFFFF_FFFF_8765_4321};
        mv[5] = '{5'b11011, 64'h6000, 64'h0123_4567_89AB_CDEF, 64'h0,                  12, 1, 0, 1, 0, 64'h6000, 1, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0};
        mv[6] = '{5'b10101, 64'h5002, 64'h0,                  64'h0000_0000_F00D_0000, 11, 1, 1, 0, 1, 64'h5000, 0, 8'h0C, 64'h0,                  1, 1, 64'hF00D};

        idle_inputs();
        rst = 1'b1;
        #2;
        check("rst_wb_we",    {63'd0, rdWriteEnableW}, 64'd0);
        check("rst_wb_addr",  {59'd0, rdWriteAddrW}, 64'd0);
        check("rst_wb_data",  rdWriteDataW, 64'd0);
        check("rst_misalign", {63'd0, misalignW}, 64'd0);
        check("rst_req",      {63'd0, memReq}, 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        foreach (av[i]) begin
            validM         = av[i].valid;
            memOpM         = av[i].op;
            aluResM        = av[i].alu;
            rdWriteAddrM   = av[i].rd;
            rdWriteEnableM = av[i].en;
            #1;
            check($sformatf("alu%0d_stall", i), {63'd0, stallM}, 64'd0);
            check($sformatf("alu%0d_req", i),   {63'd0, memReq}, 64'd0);
            step();
            check($sformatf("alu%0d_we", i),   {63'd0, rdWriteEnableW}, {63'd0, av[i].exp_we});
            check($sformatf("alu%0d_addr", i), {59'd0, rdWriteAddrW}, {59'd0, av[i].exp_addr});
            check($sformatf("alu%0d_data", i), rdWriteDataW, av[i].exp_data);
            check($sformatf("alu%0d_misalign", i), {63'd0, misalignW}, 64'd0);
        end
        idle_inputs();
        step();

        foreach (mv[i]) run_mem(mv[i], $sformatf("mem%0d", i));

`ifdef MEM_MISALIGN_CHECK_EN
        validM         = 1'b1;
        memOpM         = 5'b10010;
        aluResM        = 64'h1002;
        rdWriteAddrM   = 5'd6;
        rdWriteEnableM = 1'b1;
        #1;
        check("mis_stall", {63'd0, stallM}, 64'd0);
        check("mis_req",   {63'd0, memReq}, 64'd0);
        step();
        check("mis_flag",  {63'd0, misalignW}, 64'd1);
        check("mis_we",    {63'd0, rdWriteEnableW}, 64'd0);
        check("mis_req2",  {63'd0, memReq}, 64'd0);
        idle_inputs();
        step();
        check("mis_flag_clear", {63'd0, misalignW}, 64'd0);
`else
        run_mem('{5'b11010, 64'h7006, 64'h1122_3344, 64'h0, 13, 1, 0, 0, 0,
                  64'h7000, 1, 8'hC0, 64'h3344_0000_0000_0000, 0, 0, 64'h0}, "trunc");
`endif

        // Reset in the middle of an access waiting for its response.
        validM         = 1'b1;
        memOpM         = 5'b10010;
        aluResM        = 64'h100;
        rdWriteAddrM   = 5'd4;
        rdWriteEnableM = 1'b1;
        step();
        memReady = 1'b1;
        step();
        memReady = 1'b0;
        #1;
        check("resp_stall", {63'd0, stallM}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_req",     {63'd0, memReq}, 64'd0);
        check("midrst_stall",   {63'd0, stallM}, 64'd0);
        check("midrst_wb_we",   {63'd0, rdWriteEnableW}, 64'd0);
        check("midrst_wb_addr", {59'd0, rdWriteAddrW}, 64'd0);
        check("midrst_wb_data", rdWriteDataW, 64'd0);
        idle_inputs();
        step();
        rst = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 64'hCAFE;
        step();
        memRvalid = 1'b0;
        check("stale_rv_we",    {63'd0, rdWriteEnableW}, 64'd0);
        check("stale_rv_stall", {63'd0, stallM}, 64'd0);
        check("stale_rv_req",   {63'd0, memReq}, 64'd0);
        step();
        check("stale_rv_we2",   {63'd0, rdWriteEnableW}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX→MEM pipeline interface. Takes the registered ALU result, rd write enable and rd address from EX.
- For non-memory ops, passes the ALU result to WB after one register stage.
- For load/store ops, runs a multi-cycle request/response handshake with data memory, stalls upstream while the access is in flight, and formats load data before registering it into the MEM→WB outputs.

Parameters:
- DATA_W, 64, datapath, address and memory data width; 64-bit `DATA_BUS.
- RD_W, 5, register-file address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- validM  in  1  instruction in MEM is valid
- aluResM  in  DATA_W  ALU result; the effective address for memory ops
- storeDataM  in  DATA_W  rs2 data for stores
- memOpM  in  5  [4]=mem op, [3]=store(1)/load(0), [2]=unsigned load, [1:0]=size (0=B,1=H,2=W,3=D)
- rdWriteEnableM  in  1  rd write enable from EX
- rdWriteAddrM  in  RD_W  rd address from EX
- stallM  out  1  hold EX/MEM inputs stable; combinational
- memReq  out  1  memory request valid
- memWe  out  1  1=write
- memAddr  out  DATA_W  byte address, 8-byte aligned (low 3 bits zero)
- memWdata  out  DATA_W  lane-shifted store data
- memWstrb  out  8  byte strobes
- memReady  in  1  memory accepts request this cycle
- memRvalid  in  1  read data valid / write acknowledge
- memRdata  in  DATA_W  aligned 64-bit read word
- rdWriteEnableW  out  1  registered WB write enable
- rdWriteAddrW  out  RD_W  registered WB address
- rdWriteDataW  out  DATA_W  registered WB data
- misalignW  out  1  registered misaligned-access flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=IDLE. All registered outputs (rdWriteEnableW, rdWriteAddrW, rdWriteDataW, misalignW) and the captured-data register are 0. memReq=0.
- Non-mem op (memOpM[4]=0 or validM=0): stallM=0. At the next edge: rdWriteEnableW <= validM & rdWriteEnableM & (rdWriteAddrM!=0); rdWriteAddrW <= rdWriteAddrM; rdWriteDataW <= aluResM. Latency 1 cycle.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: if validM & memOpM[4], set stallM=1 and go to REQ.
  - REQ: memReq=1. memAddr, memWe, memWdata and memWstrb are driven from the held inputs. On memReady: if memRvalid is also high in the same cycle, capture data and go to DONE; otherwise go to RESP.
  - RESP: memReq=0. On memRvalid, capture memRdata and go to DONE.
  - DONE: stallM=0. WB registers load at this edge. Go to IDLE.
- stallM=1 in IDLE when a mem op is present, and in REQ and RESP.
- While stallM=1, the WB registers load a bubble: rdWriteEnableW <= 0 and misalignW <= 0. rdWriteAddrW and rdWriteDataW hold their values.
- Minimum mem-op latency: inputs presented in cycle 0, memReady and memRvalid both high in cycle 1, WB outputs valid in cycle 3.
- Byte lane: off = aluResM[2:0].
  - memWstrb = ({1,3,15,255}[size]) << off, truncated to 8 bits.
  - memWdata = storeDataM << (8*off).
- Load data: d = memRdata >> (8*off), truncated to the size width.
  - If memOpM[2]=1, zero-extend to 64 bits; otherwise sign-extend.
  - rdWriteEnableW = rdWriteEnableM & (rdWriteAddrM!=0).
- Store: memWe=1 and the FSM still waits for memRvalid (write ack). rdWriteEnableW <= 0 at DONE.
- Writes to x0 are suppressed in all cases.
- memRvalid is ignored in IDLE and REQ-without-memReady; this covers stale responses after reset.
- Reset mid-access: the FSM returns to IDLE immediately, memReq drops asynchronously and no WB write is produced.
- Upstream must hold its inputs stable while stallM=1. The block does not re-latch them.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined: a mem op with aluResM not aligned to its size (H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0) issues no memory request and does not stall. At the next edge, rdWriteEnableW <= 0 and misalignW <= 1 for one cycle.
- Undefined: misalignW is tied to 0. Misaligned accesses are issued as-is, with strobes truncated to 8 bits, and load data is taken from the truncated shifted word.

Test Plan:
- Reset asserted mid-RESP → memReq=0 and stallM=0 immediately; all WB outputs 0. A memRvalid pulse after reset release produces no WB write.
- ALU op: aluResM=0x1234, rdWriteAddrM=5, enable=1 → next cycle rdWriteEnableW=1, rdWriteAddrW=5, rdWriteDataW=0x1234, stallM=0.
- LB signed at addr 0x1003, memRdata=0x00000000_80000000, memReady and memRvalid both in the REQ cycle → stallM high for 2 cycles; rdWriteDataW=0xFFFFFFFF_FFFFFF80 in cycle 3. The same case with LBU gives 0x80.
- SH at addr 0x2006, storeDataM=0xABCD, memReady delayed 2 cycles, memRvalid 3 cycles later → memWstrb=0xC0, memWdata=0xABCD<<48, memAddr=0x2000; rdWriteEnableW=0; stallM stays high until DONE.
- LD to rd=0 → memory access completes and rdWriteEnableW=0.
- MEM_MISALIGN_CHECK_EN defined, LW at 0x1002 → memReq never asserts, stallM=0, next cycle misalignW=1 and rdWriteEnableW=0.
